// File: rtl/icache_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_arb_pkg
// Description : Shared types and constants for the icache data-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } arb_state_e;

    // Byte-enable bit replicated across the bank word; every access is full-width.
    localparam logic c_be_bit = 1'b1;

endpackage : icache_arb_pkg
`default_nettype wire

// File: rtl/icache_starve_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_starve_cnt
// Description : Saturating counter of denied fetch cycles with limit-hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIMIT_V);

endmodule : icache_starve_cnt
`default_nettype wire

// File: rtl/icache_data_bank_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_data_bank_arb
// Description : Shares one icache data bank between fetch reads and refill writes.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_data_bank_arb
    import icache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 128,
    parameter int BEATS_PER_LINE = 4,
    parameter int STARVE_LIMIT   = 4,
    localparam int LINE_W        = ADDR_WIDTH - $clog2(BEATS_PER_LINE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req_i,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr_i,
    output logic                    fetch_gnt_o,
    output logic                    fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
    input  logic                    refill_start_i,
    input  logic [LINE_W-1:0]       refill_line_i,
    output logic                    refill_busy_o,
    input  logic                    refill_valid_i,
    input  logic [DATA_WIDTH-1:0]   refill_data_i,
    output logic                    refill_ready_o,
    output logic                    refill_done_o,
    output logic                    bank_req_o,
    output logic                    bank_write_o,
    output logic [ADDR_WIDTH-1:0]   bank_raddr_o,
    output logic [ADDR_WIDTH-1:0]   bank_waddr_o,
    output logic [DATA_WIDTH-1:0]   bank_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bank_be_o,
    input  logic [DATA_WIDTH-1:0]   bank_rdata_i
);
    localparam int OFF_W = $clog2(BEATS_PER_LINE);
    localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(BEATS_PER_LINE - 1);

    arb_state_e        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              rvalid_q;
    logic              done_q, done_d;

    logic w_gnt;
    logic w_ready;
    logic w_hs;
    logic w_blocked;
    logic w_force;
    logic w_starve_inc;
    logic w_starve_clr;
    logic w_starve_hit;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        w_gnt        = 1'b0;
        w_ready      = 1'b0;
        w_hs         = 1'b0;
        w_blocked    = 1'b0;
        w_force      = 1'b0;
        w_starve_inc = 1'b0;
        w_starve_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_gnt        = fetch_req_i;
                w_starve_clr = 1'b1;
                if (refill_start_i) begin
                    state_d = ST_REFILL;
                    line_d  = refill_line_i;
                    beat_d  = '0;
                end
            end
            ST_REFILL: begin
                // Fetches into the line being written never get through, starved or not.
                w_blocked    = (fetch_addr_i[ADDR_WIDTH-1:OFF_W] == line_q);
                w_force      = w_starve_hit & fetch_req_i & ~w_blocked;
                w_gnt        = w_force;
                w_ready      = ~w_force;
                w_starve_clr = w_force;
                w_starve_inc = fetch_req_i & ~w_blocked & ~w_gnt;
                w_hs         = w_ready & refill_valid_i;
                if (w_hs) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            rvalid_q <= w_gnt;
            done_q   <= done_d;
        end
    end

    icache_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_starve_inc),
        .clr_i (w_starve_clr),
        .hit_o (w_starve_hit)
    );

    assign fetch_gnt_o    = w_gnt;
    assign fetch_rvalid_o = rvalid_q;
    assign fetch_rdata_o  = bank_rdata_i;
    assign refill_busy_o  = (state_q == ST_REFILL);
    assign refill_ready_o = w_ready;
    assign refill_done_o  = done_q;
    assign bank_req_o     = w_gnt | w_hs;
    assign bank_write_o   = w_hs;
    assign bank_raddr_o   = fetch_addr_i;
    assign bank_waddr_o   = {line_q, beat_q};
    assign bank_wdata_o   = refill_data_i;
    assign bank_be_o      = {(DATA_WIDTH/8){c_be_bit}};

endmodule : icache_data_bank_arb
`default_nettype wire
